seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Sequential signed (two's-complement) integer divider, the inverse operation of the team's Booth multiplier datapath.
- Uses the same shift/subtract/count structure: a partial-remainder shift register, a quotient shift register, a divisor holding register, an add/subtract ALU and a down-counter.
- Contains its own control FSM with a start/done handshake.
- Sits beside the multiplier in the arithmetic unit and shares its operand width.

Parameters:
- WIDTH, 16, operand and result width in bits (WIDTH >= 4).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  signed dividend; captured on the accepting edge.
- divisor  input  WIDTH  signed divisor; captured on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results are valid.
- quotient  output  WIDTH  signed quotient; held until the next accepted start.
- remainder  output  WIDTH  signed remainder; held until the next accepted start.
- div_by_zero  output  1  flag for divisor == 0; valid with done, held with the results.
- overflow  output  1  flag for most-negative / -1; valid with done, held with the results.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - busy, done, quotient, remainder, div_by_zero and overflow are all 0.
  - Internal registers and the counter are cleared.
  - Reset mid-operation aborts the operation with no done pulse.
- FSM states: IDLE, DIV, FIX.
  - IDLE: on an edge with start=1, perform the LOAD actions and go to DIV; busy=1 from that edge.
  - LOAD actions:
    - Capture sign_q = dividend[MSB] ^ divisor[MSB] and sign_r = dividend[MSB].
    - Load the quotient register with |dividend| and the divisor register with |divisor|, both as unsigned WIDTH bits (|most-negative| = 2^(WIDTH-1)).
    - Clear the partial remainder (WIDTH+1 bits).
    - Load the counter with WIDTH.
    - Record the zero-divisor and overflow conditions.
  - DIV: one restoring step per clock.
    - Shift {R,Q} left by 1.
    - Compute T = R - D.
    - If T >= 0: R = T and Q[0] = 1. Otherwise R is unchanged and Q[0] = 0.
    - Decrement the counter.
    - When the counter reaches 0 after the decrement, go to FIX.
  - FIX: one clock.
    - Apply signs: quotient = sign_q ? -Q : Q, remainder = sign_r ? -R : R.
    - Load the output registers, pulse done=1, clear busy, return to IDLE.
- Latency: done is high in the cycle following edge k+WIDTH+1, where edge k is the accepting edge (18 clocks for WIDTH=16). Latency is the same for all operands, including the special cases below.
- Result rules:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - dividend = quotient*divisor + remainder, with |remainder| < |divisor|.
- Divisor == 0:
  - Full latency still applies.
  - Outputs quotient = all ones, remainder = dividend, div_by_zero = 1, overflow = 0.
- dividend = -2^(WIDTH-1) and divisor = -1:
  - Outputs quotient = -2^(WIDTH-1) (wrapped), remainder = 0, overflow = 1, div_by_zero = 0.
- Flags for all other operands: both 0.
- start while busy: ignored, with no effect on the operation in flight.
- start in the same cycle done is high: the FSM is already in IDLE, so the new request is accepted on that edge.
- Output hold: quotient, remainder and flags hold their last values until the FIX of the next operation; they do not change at LOAD.
- Counter: WIDTH-bit-range down-counter (ceil(log2(WIDTH+1)) bits). It never wraps, because the FSM leaves DIV at 0.

Test Plan:
- 100 / 7, start for 1 cycle -> done exactly 18 cycles later; quotient=14, remainder=2, flags 0; busy high for the intervening cycles.
- -100 / 7 -> quotient=0xFFF2 (-14), remainder=0xFFFE (-2). Then 100 / -7 -> quotient=0xFFF2, remainder=2. Then -100 / -7 -> quotient=14, remainder=0xFFFE.
- 0x8000 / 0xFFFF -> quotient=0x8000, remainder=0, overflow=1. Then 0x8000 / 1 -> quotient=0x8000, remainder=0, overflow=0.
- 1234 / 0 -> after 18 cycles quotient=0xFFFF, remainder=1234, div_by_zero=1; outputs hold through 10 idle cycles.
- Start 1000/3, pulse start again with 5/5 at cycle 6 -> single done with quotient=333, remainder=1. Then start asserted during done with 5/5 -> accepted; second done 18 cycles later with quotient=1, remainder=0.
- Start 500/9, assert rst_n=0 at cycle 8 for 2 cycles -> busy=0 and all outputs 0 immediately (asynchronously); no done pulse. A following 500/9 -> quotient=55, remainder=5.

Source files
------------

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/done handshake and operand/result bundle for seq_divider
interface seq_divider_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential signed restoring divider, fixed WIDTH+2 cycle latency
module seq_divider #(
    parameter int WIDTH = 16
) (
    input logic         clk,
    input logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             sign_q;
    logic             sign_r;
    logic             dz_q;
    logic             ov_q;
    logic [WIDTH-1:0] quo_out;
    logic [WIDTH-1:0] rem_out;
    logic             dz_out;
    logic             ov_out;
    logic             done_q;

    logic [WIDTH-1:0] abs_dvd;
    logic [WIDTH-1:0] abs_dvs;
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] diff;
    logic [CW-1:0]    cnt_dec;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Magnitudes are unsigned, so the most-negative operand maps to 2^(WIDTH-1).
    always_comb begin
        abs_dvd = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
        abs_dvs = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        diff    = rem_sh - {2'b00, dvs_q};
        cnt_dec = cnt_q - CW'(1);
        // A zero divisor leaves Q all ones and R = |dividend|; only the quotient sign must be suppressed.
        quo_fix = dz_q ? '1 : (sign_q ? -quo_q : quo_q);
        rem_fix = sign_r ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = DIV;
            DIV:     if (cnt_dec == '0) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
            quo_out <= '0;
            rem_out <= '0;
            dz_out  <= 1'b0;
            ov_out  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        sign_r <= bus.dividend[WIDTH-1];
                        quo_q  <= abs_dvd;
                        dvs_q  <= abs_dvs;
                        rem_q  <= '0;
                        cnt_q  <= CW'(WIDTH);
                        dz_q   <= (bus.divisor == '0);
                        ov_q   <= (bus.dividend == MOST_NEG) && (bus.divisor == '1);
                    end
                end
                DIV: begin
                    if (!diff[WIDTH+1]) begin
                        rem_q <= diff[WIDTH:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q <= rem_sh[WIDTH:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_q <= cnt_dec;
                end
                FIX: begin
                    quo_out <= quo_fix;
                    rem_out <= rem_fix;
                    dz_out  <= dz_q;
                    ov_out  <= ov_q;
                    done_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.quotient    = quo_out;
    assign bus.remainder   = rem_out;
    assign bus.div_by_zero = dz_out;
    assign bus.overflow    = ov_out;
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider against a signed-arithmetic model
module tb_seq_divider;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        int           acc_edge;
        int           exp_edge;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   edge_n = 0;
    int   free_edge = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;
    logic         last_dz = 1'b0;
    logic         last_ov = 1'b0;

    seq_divider_if #(.WIDTH(W)) dif ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa;
        longint sb_;
        longint q;
        longint r;
        sa   = $signed(a);
        sb_  = $signed(b);
        e.dz = 1'b0;
        e.ov = 1'b0;
        if (sb_ == 0) begin
            q    = -1;
            r    = sa;
            e.dz = 1'b1;
        end else if (sa == -(64'sd1 <<< (W - 1)) && sb_ == -1) begin
            q    = sa;
            r    = 0;
            e.ov = 1'b1;
        end else begin
            q = sa / sb_;
            r = sa % sb_;
        end
        e.q = q[W-1:0];
        e.r = r[W-1:0];
        e.acc_edge = 0;
        e.exp_edge = 0;
        return e;
    endfunction

    // Called at a negedge; the model alone decides whether the coming edge accepts.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   acc;
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        acc = edge_n + 1;
        if (acc >= free_edge) begin
            e = model(a, b);
            e.acc_edge = acc;
            e.exp_edge = acc + W + 1;
            sb.push_back(e);
            free_edge = acc + W + 2;
        end
        @(negedge clk);
        dif.start = 1'b0;
    endtask

    task automatic wait_free();
        while (edge_n + 1 < free_edge) @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", dif.busy, 0);
        chk("rst_done", dif.done, 0);
        chk("rst_quotient", dif.quotient, 0);
        chk("rst_remainder", dif.remainder, 0);
        chk("rst_div_by_zero", dif.div_by_zero, 0);
        chk("rst_overflow", dif.overflow, 0);
        sb.delete();
        free_edge = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            last_q  <= '0;
            last_r  <= '0;
            last_dz <= 1'b0;
            last_ov <= 1'b0;
        end else begin
            if (sb.size() != 0 && edge_n >= sb[0].acc_edge)
                chk("busy", dif.busy, (edge_n < sb[0].exp_edge) ? 1 : 0);
            else
                chk("busy_idle", dif.busy, 0);
            if (dif.done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", dif.done, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_edge", 64'(edge_n), 64'(e.exp_edge));
                    chk("quotient", dif.quotient, e.q);
                    chk("remainder", dif.remainder, e.r);
                    chk("div_by_zero", dif.div_by_zero, e.dz);
                    chk("overflow", dif.overflow, e.ov);
                    last_q  <= e.q;
                    last_r  <= e.r;
                    last_dz <= e.dz;
                    last_ov <= e.ov;
                end
            end else begin
                if (sb.size() != 0 && edge_n >= sb[0].exp_edge) begin
                    chk("missing_done", dif.done, 1);
                    void'(sb.pop_front());
                end
                chk("hold_q", dif.quotient, last_q);
                chk("hold_r", dif.remainder, last_r);
                chk("hold_flags", {dif.div_by_zero, dif.overflow}, {last_dz, last_ov});
            end
        end
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           sel;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        do_reset();

        issue(16'd100, 16'd7);
        wait_free(); issue(-16'sd100, 16'd7);
        wait_free(); issue(16'd100, -16'sd7);
        wait_free(); issue(-16'sd100, -16'sd7);
        wait_free(); issue(16'h8000, 16'hFFFF);
        wait_free(); issue(16'h8000, 16'd1);
        wait_free(); issue(16'd1234, 16'd0);
        wait_free();
        repeat (10) @(negedge clk);

        issue(16'd1000, 16'd3);
        repeat (5) @(negedge clk);
        issue(16'd5, 16'd5);
        wait_free(); issue(16'd5, 16'd5);
        wait_free();
        @(negedge clk);

        issue(16'd500, 16'd9);
        repeat (7) @(negedge clk);
        do_reset();
        issue(16'd500, 16'd9);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) < 7) wait_free();
            sel = $urandom_range(0, 9);
            a = 16'($urandom);
            b = 16'($urandom);
            case (sel)
                0: b = '0;
                1: begin a = 16'h8000; b = 16'hFFFF; end
                2: b = 16'($urandom_range(1, 15));
                3: a = 16'h8000;
                4: b = -16'($urandom_range(1, 15));
                default: ;
            endcase
            issue(a, b);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", 64'(sb.size()), 0);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
